// File: rtl/instr_seq.sv
// instr_seq: MSP430 multi-cycle instruction sequencer (fetch, ext words, operand reads, autoinc, exec, writeback).
// Revision 1.0
`default_nettype none

module instr_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        mem_ack,
  input  logic        jmp_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mab_sel,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic        xw_ld,
  output logic        src_ld,
  output logic        dst_ld,
  output logic        rw,
  output logic        wb_sel,
  output logic        exec,
  output logic        done,
  output logic        unsup,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_SRC_EXT = 4'd2,
    S_SRC_RD  = 4'd3,
    S_AUTOINC = 4'd4,
    S_DST_EXT = 4'd5,
    S_DST_RD  = 4'd6,
    S_EXEC    = 4'd7,
    S_WB      = 4'd8
  } state_t;

  localparam logic [2:0] MAB_PC   = 3'd0;
  localparam logic [2:0] MAB_CALC = 3'd2;

  state_t cur_state, nxt_state;

  // Byte/word select only matters to the CALC incrementer, not to sequencing.
  logic unused_bw;
  assign unused_bw = ir[6];

  logic       is_jmp, is_f2, is_f1, is_illegal, is_unsup;
  logic       ad;
  logic [1:0] as_m;
  logic [3:0] sreg;
  logic       cg, imm, need_ext, need_src_rd, need_ai, dst_mem, wb_mem, no_wb;
  state_t     after_ai, after_rd, after_ext;

  assign is_jmp     = (ir[15:13] == 3'b001);
  assign is_f2      = (ir[15:10] == 6'b000100);
  assign is_f1      = (ir[15:12] >= 4'd4);
  assign is_illegal = !(is_jmp || is_f2 || is_f1);
  assign is_unsup   = is_f2 && ir[9];

  assign ad   = ir[7];
  assign as_m = ir[5:4];
  // Format II carries its single operand in the As/dst fields.
  assign sreg = is_f2 ? ir[3:0] : ir[11:8];

  assign cg          = (sreg == 4'd3) || ((sreg == 4'd2) && as_m[1]);
  assign imm         = (as_m == 2'b11) && (sreg == 4'd0);
  assign need_ext    = ((as_m == 2'b01) && (sreg != 4'd3)) || imm;
  assign need_src_rd = (as_m != 2'b00) && !cg && !imm;
  assign need_ai     = (as_m == 2'b11) && (sreg != 4'd0) && (sreg != 4'd2) && (sreg != 4'd3);
  assign dst_mem     = is_f1 && ad;
  assign wb_mem      = dst_mem || (is_f2 && (as_m != 2'b00));
  assign no_wb       = is_f1 && ((ir[15:12] == 4'b1001) || (ir[15:12] == 4'b1011));

  assign after_ai  = dst_mem ? S_DST_EXT : S_EXEC;
  assign after_rd  = need_ai ? S_AUTOINC : after_ai;
  assign after_ext = need_src_rd ? S_SRC_RD : after_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  logic       req_c, we_c, irld_c, pcinc_c, pcld_c, xwld_c, srcld_c, dstld_c;
  logic       rw_c, wbsel_c, exec_c, done_c, unsup_c;
  logic [2:0] mab_c;

  always_comb begin
    nxt_state = cur_state;
    req_c     = 1'b0;
    we_c      = 1'b0;
    mab_c     = MAB_PC;
    irld_c    = 1'b0;
    pcinc_c   = 1'b0;
    pcld_c    = 1'b0;
    xwld_c    = 1'b0;
    srcld_c   = 1'b0;
    dstld_c   = 1'b0;
    rw_c      = 1'b0;
    wbsel_c   = 1'b0;
    exec_c    = 1'b0;
    done_c    = 1'b0;
    unsup_c   = 1'b0;
    case (cur_state)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ack) begin
          irld_c    = 1'b1;
          pcinc_c   = 1'b1;
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_jmp) begin
          nxt_state = S_EXEC;
        end else if (is_illegal || is_unsup) begin
          unsup_c   = 1'b1;
          nxt_state = S_FETCH;
        end else if (need_ext) begin
          nxt_state = S_SRC_EXT;
        end else begin
          nxt_state = after_ext;
        end
      end
      S_SRC_EXT: begin
        req_c = 1'b1;
        if (mem_ack) begin
          xwld_c    = 1'b1;
          pcinc_c   = 1'b1;
          nxt_state = after_ext;
        end
      end
      S_SRC_RD: begin
        req_c = 1'b1;
        mab_c = MAB_CALC;
        if (mem_ack) begin
          srcld_c   = 1'b1;
          nxt_state = after_rd;
        end
      end
      S_AUTOINC: begin
        rw_c      = 1'b1;
        wbsel_c   = 1'b1;
        nxt_state = after_ai;
      end
      S_DST_EXT: begin
        req_c = 1'b1;
        if (mem_ack) begin
          xwld_c    = 1'b1;
          pcinc_c   = 1'b1;
          nxt_state = S_DST_RD;
        end
      end
      S_DST_RD: begin
        req_c = 1'b1;
        mab_c = MAB_CALC;
        if (mem_ack) begin
          dstld_c   = 1'b1;
          nxt_state = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_c = 1'b1;
        if (is_jmp) begin
          pcld_c    = jmp_taken;
          done_c    = 1'b1;
          nxt_state = S_FETCH;
        end else if (no_wb) begin
          done_c    = 1'b1;
          nxt_state = S_FETCH;
        end else begin
          nxt_state = S_WB;
        end
      end
      S_WB: begin
        if (wb_mem) begin
          req_c = 1'b1;
          we_c  = 1'b1;
          mab_c = MAB_CALC;
          if (mem_ack) begin
            done_c    = 1'b1;
            nxt_state = S_FETCH;
          end
        end else begin
          rw_c      = 1'b1;
          done_c    = 1'b1;
          nxt_state = S_FETCH;
        end
      end
      default: nxt_state = S_FETCH;
    endcase
  end

  // Reset squelches outputs in the same cycle so an in-flight access is dropped at once.
  assign mem_req = req_c   & ~rst;
  assign mem_we  = we_c    & ~rst;
  assign mab_sel = rst ? 3'd0 : mab_c;
  assign ir_ld   = irld_c  & ~rst;
  assign pc_inc  = pcinc_c & ~rst;
  assign pc_ld   = pcld_c  & ~rst;
  assign xw_ld   = xwld_c  & ~rst;
  assign src_ld  = srcld_c & ~rst;
  assign dst_ld  = dstld_c & ~rst;
  assign rw      = rw_c    & ~rst;
  assign wb_sel  = wbsel_c & ~rst;
  assign exec    = exec_c  & ~rst;
  assign done    = done_c  & ~rst;
  assign unsup   = unsup_c & ~rst;
  assign state   = rst ? 4'd0 : cur_state;

endmodule

`default_nettype wire

// File: tb/tb_instr_seq.sv
// tb_instr_seq: table-driven and hand-sequenced checks for instr_seq.
`default_nettype none

module tb_instr_seq;

  logic        clk = 1'b0;
  logic        rst, mem_ack, jmp_taken;
  logic [15:0] ir;
  logic        mem_req, mem_we, ir_ld, pc_inc, pc_ld, xw_ld, src_ld, dst_ld;
  logic        rw, wb_sel, exec, done, unsup;
  logic [2:0]  mab_sel;
  logic [3:0]  state;
  logic [19:0] outs;

  instr_seq dut (
    .clk(clk), .rst(rst), .ir(ir), .mem_ack(mem_ack), .jmp_taken(jmp_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mab_sel(mab_sel), .ir_ld(ir_ld),
    .pc_inc(pc_inc), .pc_ld(pc_ld), .xw_ld(xw_ld), .src_ld(src_ld),
    .dst_ld(dst_ld), .rw(rw), .wb_sel(wb_sel), .exec(exec), .done(done),
    .unsup(unsup), .state(state)
  );

  assign outs = {mem_req, mem_we, mab_sel, ir_ld, pc_inc, pc_ld, xw_ld, src_ld,
                 dst_ld, rw, wb_sel, exec, done, unsup, state};

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] ir;
    logic        jt;
    int          n;
    logic [31:0] seq;   // state per cycle, first cycle in the low nibble
    int          pcinc;
    int          rw;
    int          we;
    int          dn;
    int          us;
    int          pcld;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input vec_t v, input int idx);
    int n_pcinc = 0, n_rw = 0, n_we = 0, n_dn = 0, n_us = 0, n_pcld = 0;
    logic [31:0] exp_st;
    ir        = v.ir;
    jmp_taken = v.jt;
    mem_ack   = 1'b1;
    for (int c = 0; c < v.n; c++) begin
      #1;
      exp_st = (v.seq >> (4 * c)) & 32'hF;
      check($sformatf("v%0d state c%0d", idx, c), {28'd0, state}, exp_st);
      if (mem_req)
        check($sformatf("v%0d mab c%0d", idx, c), {29'd0, mab_sel},
              ((exp_st == 0) || (exp_st == 2) || (exp_st == 5)) ? 32'd0 : 32'd2);
      n_pcinc += int'(pc_inc);
      n_rw    += int'(rw);
      n_we    += int'(mem_we);
      n_dn    += int'(done);
      n_us    += int'(unsup);
      n_pcld  += int'(pc_ld);
      if (c == v.n - 1)
        check($sformatf("v%0d done last", idx), {31'd0, done}, (v.dn != 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    #1;
    check($sformatf("v%0d back to fetch", idx), {28'd0, state}, 32'd0);
    check($sformatf("v%0d pc_inc count", idx), n_pcinc, v.pcinc);
    check($sformatf("v%0d rw count", idx), n_rw, v.rw);
    check($sformatf("v%0d mem_we count", idx), n_we, v.we);
    check($sformatf("v%0d done count", idx), n_dn, v.dn);
    check($sformatf("v%0d unsup count", idx), n_us, v.us);
    check($sformatf("v%0d pc_ld count", idx), n_pcld, v.pcld);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    //          ir       jt    n  seq            pcinc rw we dn us pcld
    vecs[0]  = '{16'h4506, 1'b0, 4, 32'h0000_8710, 1, 1, 0, 1, 0, 0}; // MOV R5,R6
    vecs[1]  = '{16'h5437, 1'b0, 6, 32'h0087_4310, 1, 2, 0, 1, 0, 0}; // ADD @R4+,R7
    vecs[2]  = '{16'h40B2, 1'b0, 7, 32'h0876_5210, 3, 0, 1, 1, 0, 0}; // MOV #imm,&x
    vecs[3]  = '{16'h2005, 1'b1, 3, 32'h0000_0710, 1, 0, 0, 1, 0, 1}; // JNE taken
    vecs[4]  = '{16'h2005, 1'b0, 3, 32'h0000_0710, 1, 0, 0, 1, 0, 0}; // JNE not taken
    vecs[5]  = '{16'h9325, 1'b0, 3, 32'h0000_0710, 1, 0, 0, 1, 0, 0}; // CMP #2,R5
    vecs[6]  = '{16'h1200, 1'b0, 2, 32'h0000_0010, 1, 0, 0, 0, 1, 0}; // PUSH
    vecs[7]  = '{16'h4596, 1'b0, 8, 32'h8765_3210, 3, 0, 1, 1, 0, 0}; // MOV 2(R5),4(R6)
    vecs[8]  = '{16'h0000, 1'b0, 2, 32'h0000_0010, 1, 0, 0, 0, 1, 0}; // illegal
    vecs[9]  = '{16'h1105, 1'b0, 4, 32'h0000_8710, 1, 1, 0, 1, 0, 0}; // RRA R5
    vecs[10] = '{16'hB586, 1'b0, 5, 32'h0007_6510, 2, 0, 0, 1, 0, 0}; // BIT R5,2(R6)
    vecs[11] = '{16'h1025, 1'b0, 5, 32'h0008_7310, 1, 0, 1, 1, 0, 0}; // RRC @R5

    rst = 1'b1; mem_ack = 1'b1; jmp_taken = 1'b0; ir = 16'h4506;
    @(negedge clk);
    #1 check("reset outs c0", {12'd0, outs}, 32'd0);
    @(negedge clk);
    #1 check("reset outs c1", {12'd0, outs}, 32'd0);
    rst = 1'b0; mem_ack = 1'b0;
    #1 check("first req", {31'd0, mem_req}, 32'd1);
    check("first state", {28'd0, state}, 32'd0);
    // Fetch wait states: stay put, no strobes
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 check($sformatf("fetch wait state k%0d", k), {28'd0, state}, 32'd0);
      check($sformatf("fetch wait strobes k%0d", k), {30'd0, ir_ld, pc_inc}, 32'd0);
      check($sformatf("fetch wait req k%0d", k), {31'd0, mem_req}, 32'd1);
    end
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // ADD @R4+,R7 with two wait states in SRC_RD
    ir = 16'h5437; mem_ack = 1'b1;
    #1 check("add wait fetch", {28'd0, state}, 32'd0);
    @(negedge clk);
    #1 check("add wait decode", {28'd0, state}, 32'd1);
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) mem_ack = 1'b1;
      #1 check($sformatf("add wait rd state k%0d", k), {28'd0, state}, 32'd3);
      check($sformatf("add wait rd req k%0d", k), {31'd0, mem_req}, 32'd1);
      check($sformatf("add wait rd mab k%0d", k), {29'd0, mab_sel}, 32'd2);
      check($sformatf("add wait src_ld k%0d", k), {31'd0, src_ld}, (k == 2) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    #1 check("add wait autoinc", {26'd0, state, rw, wb_sel}, {26'd0, 4'd4, 1'b1, 1'b1});
    @(negedge clk);
    #1 check("add wait exec", {27'd0, state, exec}, {27'd0, 4'd7, 1'b1});
    @(negedge clk);
    #1 check("add wait wb", {25'd0, state, rw, wb_sel, done}, {25'd0, 4'd8, 1'b1, 1'b0, 1'b1});
    @(negedge clk);

    // Reset while DST_RD is stalled
    ir = 16'h40B2; mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) @(negedge clk);
    mem_ack = 1'b0;
    #1 check("rst seq dst_rd", {27'd0, state, mem_req}, {27'd0, 4'd6, 1'b1});
    @(negedge clk);
    #1 check("rst seq dst_rd held", {24'd0, state, mem_req, mab_sel}, {24'd0, 4'd6, 1'b1, 3'd2});
    rst = 1'b1;
    #1 check("rst mid-access outs", {12'd0, outs}, 32'd0);
    @(negedge clk);
    #1 check("rst held outs", {12'd0, outs}, 32'd0);
    rst = 1'b0;
    #1 check("after rst", {24'd0, state, mem_req, mab_sel}, {24'd0, 4'd0, 1'b1, 3'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
